// File: rtl/common_pkg.sv
// Shared helpers for the common library: arbitration index type and a
// lowest-set-bit priority encoder usable at any width up to ARB_MAX_N.
package common_pkg;

  localparam int ARB_MAX_N    = 64;
  localparam int ARB_MAX_ID_W = $clog2(ARB_MAX_N);

  // Users narrow this to their own ID_W with a size cast.
  typedef logic [ARB_MAX_ID_W-1:0] arb_id_t;

  typedef struct packed {
    logic    vld;
    arb_id_t idx;
  } penc_t;

  // Walk from the top down so the last hit written is the lowest set bit.
  function automatic penc_t prio_enc(input logic [ARB_MAX_N-1:0] v);
    penc_t res;
    res.vld = 1'b0;
    res.idx = '0;
    for (int i = ARB_MAX_N-1; i >= 0; i--) begin
      if (v[i]) begin
        res.vld = 1'b1;
        res.idx = arb_id_t'(i);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/maske.sv
// Thermometer mask from a binary position: selects bits above/below p_i,
// optionally including p_i itself.
module maske #(
  parameter int W              = 8,
  parameter bit P_INCLUSIVE    = 1'b0,
  parameter bit LEFT_NOT_RIGHT = 1'b1,
  localparam int PW            = (W > 1) ? $clog2(W) : 1
) (
  input  logic [PW-1:0] p_i,
  output logic [W-1:0]  mask_o
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    // Comparison stays PW bits wide; every bit index fits because i < W.
    localparam logic [PW-1:0] IDX = PW'(i);
    if (LEFT_NOT_RIGHT && P_INCLUSIVE) begin : g_le
      assign mask_o[i] = (IDX >= p_i);
    end else if (LEFT_NOT_RIGHT) begin : g_lt
      assign mask_o[i] = (IDX > p_i);
    end else if (P_INCLUSIVE) begin : g_re
      assign mask_o[i] = (IDX <= p_i);
    end else begin : g_rt
      assign mask_o[i] = (IDX < p_i);
    end
  end

endmodule

// File: rtl/rr_arb.sv
// Round-robin arbiter: registered grant held until ack, zero-bubble regrant
// on ack using the just-acknowledged index as the new priority pointer.
module rr_arb
  import common_pkg::*;
#(
  parameter int  N    = 8,
  localparam int ID_W = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req_i,
  input  logic            ack_i,
  output logic [N-1:0]    gnt_o,
  output logic            gnt_vld_o,
  output logic [ID_W-1:0] gnt_id_o
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;
  typedef logic [ID_W-1:0] id_t;

  state_e         state_q, state_d;
  id_t            ptr_q, ptr_d;
  id_t            gnt_id_q, gnt_id_d;
  logic [N-1:0]   gnt_q, gnt_d;

  id_t            ptr_nxt;
  logic [N-1:0]   hi_mask, hi_req;
  penc_t          pe_hi, pe_all;
  id_t            winner;
  logic           any_req;

  // On ack the mask must already reflect the grant being retired.
  assign ptr_nxt = (state_q == BUSY && ack_i) ? gnt_id_q : ptr_q;

  maske #(.W(N), .P_INCLUSIVE(1'b0), .LEFT_NOT_RIGHT(1'b1)) u_mask (
    .p_i    (ptr_nxt),
    .mask_o (hi_mask)
  );

  assign hi_req  = req_i & hi_mask;
  assign pe_hi   = prio_enc(ARB_MAX_N'(hi_req));
  assign pe_all  = prio_enc(ARB_MAX_N'(req_i));
  assign any_req = pe_all.vld;
  assign winner  = pe_hi.vld ? id_t'(pe_hi.idx) : id_t'(pe_all.idx);

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_id_d = gnt_id_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d  = BUSY;
          gnt_id_d = winner;
        end
      end
      BUSY: begin
        if (ack_i) begin
          ptr_d = gnt_id_q;
          if (any_req) gnt_id_d = winner;
          else         state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    gnt_d = (state_d == BUSY) ? ({{(N-1){1'b0}}, 1'b1} << gnt_id_d) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= id_t'(N-1);
      gnt_id_q <= '0;
      gnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_id_q <= gnt_id_d;
      gnt_q    <= gnt_d;
    end
  end

  assign gnt_o     = gnt_q;
  assign gnt_vld_o = (state_q == BUSY);
  assign gnt_id_o  = gnt_id_q;

`ifndef SYNTHESIS
  a_req_held: assert property (@(posedge clk) disable iff (rst)
    (state_q == BUSY && !ack_i) |-> req_i[gnt_id_q]);
  a_ack_idle: assert property (@(posedge clk) disable iff (rst)
    ack_i |-> (state_q == BUSY));
  a_id_range: assert property (@(posedge clk) disable iff (rst)
    (state_q == BUSY) |-> (int'(gnt_id_q) < N));
`endif

endmodule

// File: tb/tb_rr_arb.sv
// Bench for rr_arb (N=4): directed scenarios with literal expectations plus
// protocol-legal random traffic, all compared against a circular-search model.
module tb_rr_arb;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req_i = '0;
  logic         ack_i = 1'b0;
  logic [N-1:0] gnt_o;
  logic         gnt_vld_o;
  logic [1:0]   gnt_id_o;

  int total = 0;
  int bad   = 0;
  bit started = 1'b0;

  // Model state: outstanding grant and last-granted index.
  bit m_vld = 1'b0;
  int m_id  = 0;
  int m_ptr = N-1;

  rr_arb #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_i),
    .ack_i     (ack_i),
    .gnt_o     (gnt_o),
    .gnt_vld_o (gnt_vld_o),
    .gnt_id_o  (gnt_id_o)
  );

  always #5 clk = ~clk;

  // Next winner = first requester found walking circularly from ptr+1.
  always @(posedge clk) begin
    if (rst) begin
      m_vld = 1'b0;
      m_id  = 0;
      m_ptr = N-1;
    end else if (!m_vld || ack_i) begin
      int p;
      bit found;
      p = m_vld ? m_id : m_ptr;
      m_ptr = p;
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        int idx;
        idx = (p + k) % N;
        if (!found && req_i[idx]) begin
          found = 1'b1;
          m_id  = idx;
        end
      end
      m_vld = found;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      logic [N-1:0] exp_gnt;
      exp_gnt = m_vld ? (N'(1) << m_id) : '0;
      total++;
      if (gnt_vld_o !== m_vld) begin
        bad++;
        $display("FAIL model_vld: got %b want %b at %0t", gnt_vld_o, m_vld, $time);
      end
      total++;
      if (gnt_o !== exp_gnt) begin
        bad++;
        $display("FAIL model_gnt: got %b want %b at %0t", gnt_o, exp_gnt, $time);
      end
      if (m_vld) begin
        total++;
        if (int'(gnt_id_o) != m_id) begin
          bad++;
          $display("FAIL model_id: got %0d want %0d at %0t", gnt_id_o, m_id, $time);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic [N-1:0] r, input logic a, input logic rs);
    req_i = r;
    ack_i = a;
    rst   = rs;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_gnt(input string name, input int id);
    chk({name, "_vld"}, int'(gnt_vld_o), 1);
    chk({name, "_id"},  int'(gnt_id_o), id);
    chk({name, "_gnt"}, int'(gnt_o), 1 << id);
  endtask

  initial begin
    @(negedge clk);
    step(4'b0000, 1'b0, 1'b1);
    started = 1'b1;
    step(4'b0110, 1'b0, 1'b1);
    chk("rst_vld", int'(gnt_vld_o), 0);
    chk("rst_gnt", int'(gnt_o), 0);
    chk("rst_id",  int'(gnt_id_o), 0);

    // First grant after reset, then one regrant and release to IDLE.
    step(4'b0110, 1'b0, 1'b0);
    chk_gnt("first", 1);
    step(4'b0110, 1'b1, 1'b0);
    chk_gnt("second", 2);
    step(4'b0000, 1'b1, 1'b0);
    chk("to_idle", int'(gnt_vld_o), 0);

    // Full rotation with ack held high.
    step(4'b0000, 1'b0, 1'b1);
    step(4'b1111, 1'b0, 1'b0);
    chk_gnt("rot0", 0);
    for (int i = 1; i <= 5; i++) begin
      step(4'b1111, 1'b1, 1'b0);
      chk_gnt("rot", i % N);
    end

    // Wrap: grant 2, ack with only 0 and 2 requesting.
    step(4'b1111, 1'b1, 1'b0);
    chk_gnt("pre_wrap", 2);
    step(4'b0101, 1'b1, 1'b0);
    chk_gnt("wrap", 0);

    // Hold for 5 cycles without ack, then advance.
    step(4'b1111, 1'b1, 1'b0);
    chk_gnt("hold_start", 1);
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 1'b0, 1'b0);
      chk("hold_gnt", int'(gnt_o), 2);
    end
    step(4'b1111, 1'b1, 1'b0);
    chk_gnt("hold_next", 2);

    // Single requester re-wins every cycle; dropping with ack goes IDLE.
    for (int i = 0; i < 3; i++) begin
      step(4'b0100, 1'b1, 1'b0);
      chk_gnt("single", 2);
    end
    step(4'b0000, 1'b1, 1'b0);
    chk("single_idle", int'(gnt_vld_o), 0);

    // Reset mid-BUSY drops the grant and restores ptr to N-1.
    step(4'b1000, 1'b0, 1'b0);
    chk_gnt("busy3", 3);
    step(4'b1000, 1'b0, 1'b1);
    chk("rst_busy", int'(gnt_vld_o), 0);
    step(4'b1001, 1'b0, 1'b0);
    chk_gnt("post_rst", 0);

    // Random protocol-legal traffic; the model check runs every cycle.
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] r;
      logic a;
      logic rs;
      r  = N'($urandom);
      a  = m_vld ? 1'($urandom_range(0, 1)) : 1'b0;
      rs = ($urandom_range(0, 63) == 0);
      if (m_vld && !a) r[m_id] = 1'b1;
      step(r, a, rs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
